// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch target buffer.
// Entry tag/target fields are held at BP_XLEN_MAX width and zero-extended, so
// one packed entry type serves every XLEN/ENTRIES geometry; unused upper bits
// are constant zero and fall away in synthesis.
package bpred_pkg;

  localparam int unsigned BP_XLEN_MAX = 64;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t SNT = 2'b00;
  localparam bp_cnt_t WNT = 2'b01;
  localparam bp_cnt_t WT  = 2'b10;
  localparam bp_cnt_t ST  = 2'b11;

  typedef struct packed {
    logic                   valid;
    logic                   jump;
    logic [BP_XLEN_MAX-1:0] tag;
    logic [BP_XLEN_MAX-1:0] target;
    bp_cnt_t                cnt;
  } bp_entry_t;

  localparam bp_entry_t BP_ENTRY_RST = '{
    valid:  1'b0,
    jump:   1'b0,
    tag:    '0,
    target: '0,
    cnt:    WNT
  };

  // Table index: PC word bits [idx_w+1:2], returned zero-extended.
  function automatic logic [BP_XLEN_MAX-1:0] bp_idx(
    input logic [BP_XLEN_MAX-1:0] pc,
    input int unsigned            idx_w
  );
    logic [BP_XLEN_MAX-1:0] mask;
    mask = (BP_XLEN_MAX'(1) << idx_w) - BP_XLEN_MAX'(1);
    return (pc >> 2) & mask;
  endfunction

  // Tag: PC bits above the index, returned zero-extended.
  function automatic logic [BP_XLEN_MAX-1:0] bp_tag(
    input logic [BP_XLEN_MAX-1:0] pc,
    input int unsigned            idx_w
  );
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bpred_sat_cnt.sv
// 2-bit saturating up/down counter next-state logic (00 floor, 11 ceiling).
module bpred_sat_cnt
  import bpred_pkg::*;
(
  input  bp_cnt_t cnt,
  input  logic    up,
  output bp_cnt_t nxt
);

  // Step toward taken or not-taken, holding at the ends.
  always_comb begin
    nxt = cnt;
    if (up) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with 2-bit bimodal direction counters.
// Lookup in F is combinational on PCF; resolution and training happen in E.
// Optional feature: define BPRED_STATS_EN to add resolved-branch and
// mispredict counters; otherwise BrCount/MispCount are tied to zero.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            UpdateE,
  input  logic            IsJumpE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PC_Plus4E,
  input  logic            TakenE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BrCount,
  output logic [31:0]     MispCount
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  bp_entry_t              tbl [ENTRIES];

  logic [IDX_W-1:0]       idx_f;
  logic [IDX_W-1:0]       idx_e;
  logic [BP_XLEN_MAX-1:0] tag_f;
  logic [BP_XLEN_MAX-1:0] tag_e;
  bp_entry_t              ent_f;
  bp_entry_t              ent_e;
  logic                   hit_f;
  logic                   hit_e;
  bp_cnt_t                cnt_nxt;

  // Fetch-side lookup: reads pre-update table contents.
  always_comb begin
    idx_f       = IDX_W'(bp_idx(BP_XLEN_MAX'(PCF), IDX_W));
    tag_f       = bp_tag(BP_XLEN_MAX'(PCF), IDX_W);
    ent_f       = tbl[idx_f];
    hit_f       = ent_f.valid && (ent_f.tag == tag_f);
    PredTakenF  = hit_f && (ent_f.jump || ent_f.cnt[1]);
    PredTargetF = PredTakenF ? XLEN'(ent_f.target) : '0;
  end

  // Execute-side resolution: mispredict detection and redirect target.
  always_comb begin
    idx_e       = IDX_W'(bp_idx(BP_XLEN_MAX'(PCE), IDX_W));
    tag_e       = bp_tag(BP_XLEN_MAX'(PCE), IDX_W);
    ent_e       = tbl[idx_e];
    hit_e       = ent_e.valid && (ent_e.tag == tag_e);
    MispredictE = UpdateE &&
                  ((PredTakenE != TakenE) || (TakenE && (PredTargetE != TargetE)));
    RedirectPCE = TakenE ? TargetE : PC_Plus4E;
  end

  bpred_sat_cnt u_sat_cnt (
    .cnt (ent_e.cnt),
    .up  (TakenE),
    .nxt (cnt_nxt)
  );

  // Table training: hits adjust counter/target/jump, taken misses allocate.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl[i] <= BP_ENTRY_RST;
      end
    end else if (UpdateE) begin
      if (hit_e) begin
        tbl[idx_e].cnt  <= cnt_nxt;
        tbl[idx_e].jump <= IsJumpE;
        if (TakenE) tbl[idx_e].target <= BP_XLEN_MAX'(TargetE);
      end else if (TakenE) begin
        tbl[idx_e] <= '{
          valid:  1'b1,
          jump:   IsJumpE,
          tag:    tag_e,
          target: BP_XLEN_MAX'(TargetE),
          cnt:    WT
        };
      end
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] misp_cnt;

  // Free-running statistics; both wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      br_cnt   <= '0;
      misp_cnt <= '0;
    end else begin
      if (UpdateE)     br_cnt   <= br_cnt + 32'd1;
      if (MispredictE) misp_cnt <= misp_cnt + 32'd1;
    end
  end

  assign BrCount   = br_cnt;
  assign MispCount = misp_cnt;
`else
  assign BrCount   = '0;
  assign MispCount = '0;
`endif

endmodule

// File: tb/tb_bpred_btb.sv
// Directed scoreboard bench for bpred_btb (ENTRIES=64, XLEN=32).
module tb_bpred_btb;

  logic        clk;
  logic        n_rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE;
  logic        IsJumpE;
  logic [31:0] PCE;
  logic [31:0] PC_Plus4E;
  logic        TakenE;
  logic [31:0] TargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BrCount;
  logic [31:0] MispCount;

  bpred_btb #(.ENTRIES(64), .XLEN(32)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .UpdateE     (UpdateE),
    .IsJumpE     (IsJumpE),
    .PCE         (PCE),
    .PC_Plus4E   (PC_Plus4E),
    .TakenE      (TakenE),
    .TargetE     (TargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .MispredictE (MispredictE),
    .RedirectPCE (RedirectPCE),
    .BrCount     (BrCount),
    .MispCount   (MispCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int { S_PTF, S_PTGT, S_MISP, S_REDIR, S_BR, S_MC } sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mc = 0;

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef BPRED_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic push(input string tag, input sel_t sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_PTF:   obs = {31'd0, PredTakenF};
        S_PTGT:  obs = PredTargetF;
        S_MISP:  obs = {31'd0, MispredictE};
        S_REDIR: obs = RedirectPCE;
        S_BR:    obs = BrCount;
        default: obs = MispCount;
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Compare at the negedge, then advance just past the next posedge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pcf,
                        input logic ptf, input logic [31:0] ptgt);
    UpdateE = 1'b0; IsJumpE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
    PCF = pcf;
    push({tag, "_ptf"}, S_PTF, {31'd0, ptf});
    push({tag, "_ptgt"}, S_PTGT, ptgt);
    push({tag, "_idle_misp"}, S_MISP, 32'd0);
    tick();
  endtask

  task automatic upd(input string tag, input logic [31:0] pce, input logic taken,
                     input logic [31:0] tgt, input logic jump, input logic pt,
                     input logic [31:0] ptg, input logic [31:0] pcf,
                     input logic misp, input logic [31:0] redir,
                     input logic ptf, input logic [31:0] ptgt);
    UpdateE = 1'b1; PCE = pce; PC_Plus4E = pce + 32'd4; TakenE = taken;
    TargetE = tgt; IsJumpE = jump; PredTakenE = pt; PredTargetE = ptg; PCF = pcf;
    push({tag, "_misp"}, S_MISP, {31'd0, misp});
    push({tag, "_redir"}, S_REDIR, redir);
    push({tag, "_ptf"}, S_PTF, {31'd0, ptf});
    push({tag, "_ptgt"}, S_PTGT, ptgt);
    exp_br = exp_br + 32'd1;
    if (misp) exp_mc = exp_mc + 32'd1;
    tick();
  endtask

  task automatic stats(input string tag);
    push({tag, "_br"}, S_BR, stat(exp_br));
    push({tag, "_mc"}, S_MC, stat(exp_mc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; PCF = 32'h1000_0000; UpdateE = 1'b0; IsJumpE = 1'b0;
    PCE = '0; PC_Plus4E = '0; TakenE = 1'b0; TargetE = '0;
    PredTakenE = 1'b0; PredTargetE = '0;

    push("rst_ptf", S_PTF, 32'd0);
    push("rst_ptgt", S_PTGT, 32'd0);
    stats("rst");
    tick();
    n_rst = 1'b1;

    // Allocate, then counter walk down to the floor and back up.
    upd("A", 32'h1000_0010, 1, 32'h1000_0040, 0, 0, 0, 32'h1000_0010, 1, 32'h1000_0040, 0, 0);
    lookup("A_next", 32'h1000_0010, 1, 32'h1000_0040);
    upd("B", 32'h1000_0010, 0, 32'h1000_0777, 0, 1, 32'h1000_0040, 32'h1000_0010, 1, 32'h1000_0014, 1, 32'h1000_0040);
    lookup("B_next", 32'h1000_0010, 0, 0);
    upd("C", 32'h1000_0010, 0, 32'h1000_0777, 0, 0, 0, 32'h1000_0010, 0, 32'h1000_0014, 0, 0);
    upd("D", 32'h1000_0010, 0, 32'h1000_0777, 0, 0, 0, 32'h1000_0010, 0, 32'h1000_0014, 0, 0);
    lookup("D_next", 32'h1000_0010, 0, 0);
    upd("E", 32'h1000_0010, 1, 32'h1000_0040, 0, 0, 0, 32'h1000_0010, 1, 32'h1000_0040, 0, 0);
    lookup("floor", 32'h1000_0010, 0, 0);
    upd("F", 32'h1000_0010, 1, 32'h1000_0040, 0, 0, 0, 32'h1000_0010, 1, 32'h1000_0040, 0, 0);
    lookup("F_next", 32'h1000_0010, 1, 32'h1000_0040);
    upd("G", 32'h1000_0010, 1, 32'h1000_0040, 0, 1, 32'h1000_0040, 32'h1000_0010, 0, 32'h1000_0040, 1, 32'h1000_0040);
    upd("H", 32'h1000_0010, 1, 32'h1000_0044, 0, 1, 32'h1000_0040, 32'h1000_0010, 1, 32'h1000_0044, 1, 32'h1000_0040);
    upd("I", 32'h1000_0010, 0, 32'h1000_0777, 0, 1, 32'h1000_0044, 32'h1000_0010, 1, 32'h1000_0014, 1, 32'h1000_0044);
    lookup("ceiling", 32'h1000_0010, 1, 32'h1000_0044);

    // Aliasing on index 4: other tag misses, then replaces the entry.
    lookup("alias_miss", 32'h1000_0110, 0, 0);
    upd("J", 32'h1000_0110, 1, 32'h1000_0200, 0, 0, 0, 32'h1000_0110, 1, 32'h1000_0200, 0, 0);
    lookup("evicted", 32'h1000_0010, 0, 0);
    lookup("unaligned", 32'h1000_0112, 1, 32'h1000_0200);
    upd("K", 32'h1000_0020, 0, 32'h1000_0500, 0, 0, 0, 32'h1000_0020, 0, 32'h1000_0024, 0, 0);
    lookup("nt_noalloc", 32'h1000_0020, 0, 0);

    // Jump entry: retrain target, same-cycle lookup sees the old one.
    upd("L", 32'h1000_0300, 1, 32'h1000_0040, 1, 0, 0, 32'h1000_0300, 1, 32'h1000_0040, 0, 0);
    lookup("L_next", 32'h1000_0300, 1, 32'h1000_0040);
    upd("M", 32'h1000_0300, 1, 32'h1000_0080, 1, 1, 32'h1000_0040, 32'h1000_0300, 1, 32'h1000_0080, 1, 32'h1000_0040);
    lookup("M_next", 32'h1000_0300, 1, 32'h1000_0080);
    upd("N", 32'h1000_0300, 0, 32'h1000_0B00, 1, 1, 32'h1000_0080, 32'h1000_0300, 1, 32'h1000_0304, 1, 32'h1000_0080);
    upd("O", 32'h1000_0300, 0, 32'h1000_0B00, 1, 1, 32'h1000_0080, 32'h1000_0300, 1, 32'h1000_0304, 1, 32'h1000_0080);
    lookup("jump_force", 32'h1000_0300, 1, 32'h1000_0080);
    upd("P", 32'h1000_0300, 0, 32'h1000_0B00, 0, 1, 32'h1000_0080, 32'h1000_0300, 1, 32'h1000_0304, 1, 32'h1000_0080);
    lookup("P_next", 32'h1000_0300, 0, 0);
    stats("run");
    lookup("run_idle", 32'h1000_0000, 0, 0);

    // Asynchronous reset arriving with an update pending.
    UpdateE = 1'b1; PCE = 32'h1000_0300; PC_Plus4E = 32'h1000_0304; TakenE = 1'b1;
    TargetE = 32'h1000_0900; IsJumpE = 1'b0; PredTakenE = 1'b0; PredTargetE = '0;
    PCF = 32'h1000_0110;
    #2 n_rst = 1'b0;
    exp_br = 0; exp_mc = 0;
    push("mrst_ptf", S_PTF, 32'd0);
    push("mrst_ptgt", S_PTGT, 32'd0);
    push("mrst_misp", S_MISP, 32'd1);
    push("mrst_redir", S_REDIR, 32'h1000_0900);
    stats("mrst");
    tick();
    n_rst = 1'b1;
    lookup("post_rst_a", 32'h1000_0110, 0, 0);
    lookup("post_rst_b", 32'h1000_0300, 0, 0);
    stats("post_rst");
    lookup("post_rst_c", 32'h1000_0010, 0, 0);
    upd("Q", 32'h1000_0010, 1, 32'h1000_0040, 0, 0, 0, 32'h1000_0010, 1, 32'h1000_0040, 0, 0);
    stats("Q");
    lookup("Q_next", 32'h1000_0010, 1, 32'h1000_0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
